// File: rtl/stencil_ub_pkg.sv
// rtl/stencil_ub_pkg.sv - shared helpers for the stencil unified buffer
package stencil_ub_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Keeps degenerate widths (e.g. a single row slot) at one bit.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  function automatic int window_count(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/stencil_window_ub_if.sv
// rtl/stencil_window_ub_if.sv - pixel-in / window-out handshake bundle
interface stencil_window_ub_if
  import stencil_ub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int K     = 3
);
  localparam int XW = max1(clog2(IMG_W));
  localparam int YW = max1(clog2(IMG_H));

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [K*K*WIDTH-1:0]   out_taps;
  logic [XW-1:0]          out_x;
  logic [YW-1:0]          out_y;
  logic                   out_last;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_taps, out_x, out_y, out_last
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_taps, out_x, out_y, out_last
  );

endinterface

// File: rtl/stencil_line_ram.sv
// rtl/stencil_line_ram.sv - (K-1) row slots, one write port, K-1 age-ordered async reads
module stencil_line_ram
  import stencil_ub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int K     = 3,
  parameter int XW    = 6,
  parameter int RPW   = 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [RPW-1:0]         rowptr,
  input  logic [XW-1:0]          col,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [(K-1)*WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [K-1][IMG_W];

  // Slot rowptr holds the oldest row until it is overwritten; younger rows follow it.
  function automatic logic [RPW-1:0] slot_of(input logic [RPW-1:0] base, input int age);
    int s;
    s = int'(base) + age;
    if (s >= K - 1) s = s - (K - 1);
    return RPW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[rowptr][col] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int a = 0; a < K - 1; a++) begin
      rd_data[a*WIDTH +: WIDTH] = mem[slot_of(rowptr, a)][col];
    end
  end

endmodule

// File: rtl/stencil_window_ub.sv
// rtl/stencil_window_ub.sv - self-addressed line buffer emitting one KxK window per pixel
module stencil_window_ub
  import stencil_ub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int K     = 3
) (
  input  logic clk,
  input  logic rst,
  stencil_window_ub_if.slave bus
);

  localparam int XW  = max1(clog2(IMG_W));
  localparam int YW  = max1(clog2(IMG_H));
  localparam int RPW = max1(clog2(K - 1));

  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0]  X_MIN   = XW'(K - 1);
  localparam logic [YW-1:0]  Y_MIN   = YW'(K - 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(K - 2);

  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic [RPW-1:0]           rp_q;
  logic [WIDTH-1:0]         win [K][K];
  logic [WIDTH-1:0]         new_col [K];
  logic [(K-1)*WIDTH-1:0]   ram_rd;
  logic [K*K*WIDTH-1:0]     taps_flat;
  logic                     ov_q;
  logic                     last_q;
  logic [XW-1:0]            ox_q;
  logic [YW-1:0]            oy_q;
  logic                     accept;
  logic                     emit;
  logic                     row_end;
  logic                     frame_end;

  assign bus.in_ready  = !ov_q || bus.out_ready;
  // A flush cycle drops its pixel, so it must not reach the RAM either.
  assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
  assign emit          = (x_q >= X_MIN) && (y_q >= Y_MIN);
  assign row_end       = (x_q == X_LAST);
  assign frame_end     = row_end && (y_q == Y_LAST);

  assign bus.out_valid = ov_q;
  assign bus.out_last  = last_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_taps  = taps_flat;

  stencil_line_ram #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .K     (K),
    .XW    (XW),
    .RPW   (RPW)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .rowptr  (rp_q),
    .col     (x_q),
    .wr_data (bus.in_data),
    .rd_data (ram_rd)
  );

  always_comb begin
    for (int r = 0; r < K; r++) new_col[r] = '0;
    for (int r = 0; r < K - 1; r++) new_col[r] = ram_rd[r*WIDTH +: WIDTH];
    new_col[K-1] = bus.in_data;
  end

  always_comb begin
    taps_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        taps_flat[tap_idx(r, c, K)*WIDTH +: WIDTH] = win[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      rp_q   <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win[r][c] <= '0;
      end
    end else if (bus.flush) begin
      x_q    <= '0;
      y_q    <= '0;
      rp_q   <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
      if (row_end) begin
        x_q  <= '0;
        y_q  <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        rp_q <= (rp_q == RP_LAST) ? '0 : rp_q + RPW'(1);
      end else begin
        x_q  <= x_q + XW'(1);
      end
      ov_q   <= emit;
      last_q <= emit && frame_end;
      if (emit) begin
        ox_q <= x_q - X_MIN;
        oy_q <= y_q - Y_MIN;
      end
    end else if (bus.out_ready) begin
      ov_q   <= 1'b0;
      last_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stencil_window_ub.sv
// tb/tb_stencil_window_ub.sv - randomized self-checking bench for stencil_window_ub
module tb_stencil_window_ub;

  localparam int W  = 16;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int K  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stencil_window_ub_if #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .K(K)) bus ();

  stencil_window_ub #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K*K*W-1:0] taps;
    int               x;
    int               y;
    bit               last;
    int               cyc;
  } win_t;

  win_t exp_q[$];
  win_t obs_q[$];
  win_t mon_w;
  int   img [IH][IW];
  int   mx, my;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc_cyc = 0;
  bit   rnd_ready = 1'b0;
  int   first_win [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_w.taps = bus.out_taps;
      mon_w.x    = int'(bus.out_x);
      mon_w.y    = int'(bus.out_y);
      mon_w.last = bus.out_last;
      mon_w.cyc  = cyc;
      obs_q.push_back(mon_w);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    mx = 0;
    my = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Reference: a window is the KxK block of the current frame ending at the accepted pixel.
  task automatic model_accept(input int d);
    win_t w;
    img[my][mx] = d;
    if (mx >= K - 1 && my >= K - 1) begin
      w.taps = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w.taps[(r*K+c)*W +: W] = W'(img[my-K+1+r][mx-K+1+c]);
      w.x    = mx - K + 1;
      w.y    = my - K + 1;
      w.last = (mx == IW - 1) && (my == IH - 1);
      w.cyc  = 0;
      exp_q.push_back(w);
    end
    mx++;
    if (mx == IW) begin
      mx = 0;
      my++;
      if (my == IH) my = 0;
    end
  endtask

  task automatic send_pixel(input int d);
    bit ok;
    bit acc;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(d);
    for (int t = 0; t < 200 && !ok; t++) begin
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        model_accept(d);
        last_acc_cyc = cyc;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout pixel %0d not accepted within 200 cycles", d);
    end
  endtask

  task automatic stream(input int base, input int from, input int to);
    for (int p = from; p <= to; p++) send_pixel(base + p);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_taps !== '0 || bus.out_x !== '0 || bus.out_y !== '0 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got taps=%h x=%0d y=%0d last=%0b exp all 0",
               bus.out_taps, bus.out_x, bus.out_y, bus.out_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    logic [K*K*W-1:0] fw;
    int acc18;
    int nlast;
    reset_model();
    for (int i = 0; i < 9; i++) fw[i*W +: W] = W'(first_win[i]);
    stream(0, 0, 18);
    acc18 = last_acc_cyc;
    stream(0, 19, 47);
    drain();
    n_checks++;
    if (obs_q.size() !== 24) begin
      n_fail++;
      $display("FAIL frame_window_count got %0d exp 24", obs_q.size());
    end
    if (obs_q.size() >= 24) begin
      n_checks++;
      if (obs_q[0].taps !== fw || obs_q[0].x !== 0 || obs_q[0].y !== 0 || obs_q[0].cyc !== acc18) begin
        n_fail++;
        $display("FAIL frame_first_window got taps=%h x=%0d y=%0d cyc=%0d exp taps=%h x=0 y=0 cyc=%0d",
                 obs_q[0].taps, obs_q[0].x, obs_q[0].y, obs_q[0].cyc, fw, acc18);
      end
      n_checks++;
      if (obs_q[23].taps[8*W +: W] !== 16'd47 || obs_q[23].taps[0 +: W] !== 16'd29 ||
          obs_q[23].x !== 5 || obs_q[23].y !== 3 || obs_q[23].last !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_last_window got t8=%0d t0=%0d x=%0d y=%0d last=%0b exp 47 29 5 3 1",
                 obs_q[23].taps[8*W +: W], obs_q[23].taps[0 +: W], obs_q[23].x, obs_q[23].y, obs_q[23].last);
      end
    end
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    n_checks++;
    if (nlast !== 1) begin
      n_fail++;
      $display("FAIL frame_last_count got %0d exp 1", nlast);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL frame_win[%0d] got taps=%h x=%0d y=%0d last=%0b exp taps=%h x=%0d y=%0d last=%0b",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, obs_q[i].last,
                 exp_q[i].taps, exp_q[i].x, exp_q[i].y, exp_q[i].last);
      end
    end
  endtask

  task automatic test_hold();
    logic [K*K*W-1:0] held;
    reset_model();
    stream(0, 0, 20);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(21);
    held = exp_q[exp_q.size()-1].taps;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_taps !== held) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got valid=%0b in_ready=%0b taps=%h exp 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_taps, held);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    stream(0, 21, 47);
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL hold_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL hold_win[%0d] got taps=%h x=%0d y=%0d exp taps=%h x=%0d y=%0d",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, exp_q[i].taps, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [K*K*W-1:0] fw;
    bit leak;
    reset_model();
    for (int i = 0; i < 9; i++) fw[i*W +: W] = W'(first_win[i] + 100);
    stream(0, 0, 47);
    stream(100, 0, 47);
    drain();
    n_checks++;
    if (obs_q.size() !== 48) begin
      n_fail++;
      $display("FAIL b2b_count got %0d exp 48", obs_q.size());
    end
    if (obs_q.size() > 24) begin
      n_checks++;
      if (obs_q[24].taps !== fw) begin
        n_fail++;
        $display("FAIL b2b_first_window got %h exp %h", obs_q[24].taps, fw);
      end
      leak = 1'b0;
      for (int i = 24; i < obs_q.size(); i++)
        for (int t = 0; t < K*K; t++)
          if (obs_q[i].taps[t*W +: W] < 16'd100) leak = 1'b1;
      n_checks++;
      if (leak !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_stale_leak got leak=%0b exp 0", leak);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL b2b_win[%0d] got taps=%h x=%0d y=%0d exp taps=%h x=%0d y=%0d",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, exp_q[i].taps, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_flush();
    logic [K*K*W-1:0] fw;
    reset_model();
    for (int i = 0; i < 9; i++) fw[i*W +: W] = W'(first_win[i]);
    stream(0, 0, 29);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(30);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_out_valid got %0b exp 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    mx = 0;
    my = 0;
    stream(0, 0, 47);
    drain();
    n_checks++;
    if (obs_q.size() !== 34) begin
      n_fail++;
      $display("FAIL flush_count got %0d exp 34", obs_q.size());
    end
    if (obs_q.size() > 10) begin
      n_checks++;
      if (obs_q[10].taps !== fw || obs_q[10].x !== 0 || obs_q[10].y !== 0) begin
        n_fail++;
        $display("FAIL flush_restart_window got taps=%h x=%0d y=%0d exp %h 0 0",
                 obs_q[10].taps, obs_q[10].x, obs_q[10].y, fw);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL flush_win[%0d] got taps=%h x=%0d y=%0d exp taps=%h x=%0d y=%0d",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, exp_q[i].taps, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    reset_model();
    stream(0, 0, 28);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_valid got %0b exp 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_taps !== '0 || bus.out_x !== '0 ||
        bus.out_y !== '0 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got valid=%0b taps=%h x=%0d y=%0d last=%0b exp all 0",
               bus.out_valid, bus.out_taps, bus.out_x, bus.out_y, bus.out_last);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    stream(0, 0, 47);
    drain();
    n_checks++;
    if (obs_q.size() !== 24) begin
      n_fail++;
      $display("FAIL rstmid_count got %0d exp 24", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL rstmid_win[%0d] got taps=%h x=%0d y=%0d exp taps=%h x=%0d y=%0d",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, exp_q[i].taps, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_random_valid();
    reset_model();
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < IW * IH; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            bus.out_ready = ($urandom_range(0, 1) != 0);
            @(posedge clk);
            #1;
          end
        end
        send_pixel(f * 200 + p);
      end
    end
    rnd_ready = 1'b0;
    drain();
    n_checks++;
    if (obs_q.size() !== 48) begin
      n_fail++;
      $display("FAIL random_count got %0d exp 48", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].taps !== exp_q[i].taps || obs_q[i].x !== exp_q[i].x ||
          obs_q[i].y !== exp_q[i].y || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL random_win[%0d] got taps=%h x=%0d y=%0d last=%0b exp taps=%h x=%0d y=%0d last=%0b",
                 i, obs_q[i].taps, obs_q[i].x, obs_q[i].y, obs_q[i].last,
                 exp_q[i].taps, exp_q[i].x, exp_q[i].y, exp_q[i].last);
      end
    end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid_frame();
    test_random_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
